// File: rtl/conf_bus_pkg.sv
// Shared configuration-bus definitions: bus widths, the address/data word
// carried on the bus, and the bitwise majority voter used by TMR registers.
package conf_bus_pkg;

  localparam int CONF_AW = 16;
  localparam int CONF_DW = 16;

  // Widest register the voter handles; narrower users zero-extend.
  localparam int VOTE_W = 32;

  typedef struct packed {
    logic [CONF_AW-1:0] addr;
    logic [CONF_DW-1:0] data;
  } conf_word_t;

  // Bitwise 2-of-3 majority.
  function automatic logic [VOTE_W-1:0] vote3(
    input logic [VOTE_W-1:0] a,
    input logic [VOTE_W-1:0] b,
    input logic [VOTE_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_reg.sv
// Triple-redundant register. All three copies reload from the same D input
// every cycle and the output is their bitwise majority, so an upset in any
// single copy is masked immediately and scrubbed on the next edge.
module tmr_reg
  import conf_bus_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_c0;
  logic [W-1:0] r_c1;
  logic [W-1:0] r_c2;

  // Three independent copies, all loaded from the voted next value.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_c0 <= RST_VAL;
      r_c1 <= RST_VAL;
      r_c2 <= RST_VAL;
    end else begin
      r_c0 <= i_d;
      r_c1 <= i_d;
      r_c2 <= i_d;
    end
  end

  assign o_q = W'(vote3(VOTE_W'(r_c0), VOTE_W'(r_c1), VOTE_W'(r_c2)));

endmodule

// File: rtl/conf_write_buffer.sv
// Configuration write buffer: captures one {address, data} word per rising
// edge of the bus write strobe into a small FIFO and presents the head entry
// to the register bank, popping it on Mem_Write && Mem_Ready. Conf_Free_Out
// throttles the shift-register stage with one slot of margin. All control
// state is triple-redundant; the data storage is a plain array.
module conf_write_buffer
  import conf_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Conf_Write_In,
  input  logic [CONF_AW-1:0]       Conf_Address_In,
  input  logic [CONF_DW-1:0]       Conf_Data_In,
  output logic                     Conf_Free_Out,
  output logic                     Mem_Write,
  output logic [CONF_AW-1:0]       Mem_Address,
  output logic [CONF_DW-1:0]       Mem_Data,
  input  logic                     Mem_Ready,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow,
  input  logic                     Clear_Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] FREE_LVL = LW'(DEPTH - 2);

  // Voted control state
  logic          w_first;
  logic          w_wr_prev;
  logic [PW-1:0] w_wptr;
  logic [PW-1:0] w_rptr;
  logic [LW-1:0] w_level;
  logic          w_ovf;
  logic          w_free;

  // Next-state values
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [LW-1:0] w_level_nxt;
  logic          w_ovf_nxt;
  logic          w_free_nxt;

  // Datapath controls
  logic          w_push;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  conf_word_t    w_in_word;
  conf_word_t    w_head;

  conf_word_t    r_mem [DEPTH];

  // The first cycle after reset behaves as if the strobe was already high,
  // so a strobe held across reset release is not captured.
  assign w_push    = Conf_Write_In && !(w_wr_prev || w_first);
  assign w_full    = (w_level == FULL_LVL);
  assign w_pop     = Mem_Write && Mem_Ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  assign w_wptr_nxt  = w_wptr + PW'(w_push_ok);
  assign w_rptr_nxt  = w_rptr + PW'(w_pop);
  assign w_level_nxt = w_level + LW'(w_push_ok) - LW'(w_pop);
  assign w_ovf_nxt   = w_drop || (w_ovf && !Clear_Overflow);
  assign w_free_nxt  = (w_level_nxt <= FREE_LVL);

  assign w_in_word.addr = Conf_Address_In;
  assign w_in_word.data = Conf_Data_In;

  tmr_reg #(.W(1), .RST_VAL(1'b1)) u_first (
    .Clk(Clk), .Reset(Reset), .i_d(1'b0), .o_q(w_first)
  );

  tmr_reg #(.W(1), .RST_VAL(1'b0)) u_wr_prev (
    .Clk(Clk), .Reset(Reset), .i_d(Conf_Write_In), .o_q(w_wr_prev)
  );

  tmr_reg #(.W(PW), .RST_VAL('0)) u_wr_ptr (
    .Clk(Clk), .Reset(Reset), .i_d(w_wptr_nxt), .o_q(w_wptr)
  );

  tmr_reg #(.W(PW), .RST_VAL('0)) u_rd_ptr (
    .Clk(Clk), .Reset(Reset), .i_d(w_rptr_nxt), .o_q(w_rptr)
  );

  tmr_reg #(.W(LW), .RST_VAL('0)) u_level (
    .Clk(Clk), .Reset(Reset), .i_d(w_level_nxt), .o_q(w_level)
  );

  tmr_reg #(.W(1), .RST_VAL(1'b0)) u_overflow (
    .Clk(Clk), .Reset(Reset), .i_d(w_ovf_nxt), .o_q(w_ovf)
  );

  tmr_reg #(.W(1), .RST_VAL(1'b1)) u_free (
    .Clk(Clk), .Reset(Reset), .i_d(w_free_nxt), .o_q(w_free)
  );

  // Write accepted words into storage at the write pointer.
  // NOTE: storage has no reset; the voted level alone decides validity, and
  // leaving the array unreset lets it map onto plain RAM/flops without a
  // reset tree.
  always_ff @(posedge Clk) begin
    if (w_push_ok) begin
      r_mem[w_wptr] <= w_in_word;
    end
  end

  // Present the head entry, or zeros when the buffer is empty.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_head = '0;
    if (w_level != '0) begin
      w_head = r_mem[w_rptr];
    end
  end

  assign Mem_Write     = (w_level != '0);
  assign Mem_Address   = w_head.addr;
  assign Mem_Data      = w_head.data;
  assign Level         = w_level;
  assign Overflow      = w_ovf;
  assign Conf_Free_Out = w_free;

endmodule

// File: tb/tb_conf_write_buffer.sv
// Self-checking bench for conf_write_buffer (DEPTH=4). Accepted words are
// pushed to a scoreboard queue when driven and popped/compared as the DUT
// hands them to the register bank.
module tb_conf_write_buffer;
  import conf_bus_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Conf_Write_In;
  logic [15:0] Conf_Address_In;
  logic [15:0] Conf_Data_In;
  logic        Conf_Free_Out;
  logic        Mem_Write;
  logic [15:0] Mem_Address;
  logic [15:0] Mem_Data;
  logic        Mem_Ready;
  logic [2:0]  Level;
  logic        Overflow;
  logic        Clear_Overflow;

  int total = 0;
  int bad   = 0;

  conf_word_t sb[$];
  conf_word_t exp_w;
  logic [1:0] m_wptr;

  conf_write_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Conf_Write_In(Conf_Write_In), .Conf_Address_In(Conf_Address_In),
    .Conf_Data_In(Conf_Data_In), .Conf_Free_Out(Conf_Free_Out),
    .Mem_Write(Mem_Write), .Mem_Address(Mem_Address), .Mem_Data(Mem_Data),
    .Mem_Ready(Mem_Ready), .Level(Level), .Overflow(Overflow),
    .Clear_Overflow(Clear_Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One strobe held for 'hi' cycles, then one low cycle.
  task automatic strobe(input logic [15:0] a, input logic [15:0] d, input int hi);
    Conf_Address_In = a;
    Conf_Data_In    = d;
    Conf_Write_In   = 1'b1;
    repeat (hi) tick();
    Conf_Write_In   = 1'b0;
    tick();
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] d);
    conf_word_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
    m_wptr = m_wptr + 2'd1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Conf_Write_In = 1'b0; Conf_Address_In = '0; Conf_Data_In = '0;
    Mem_Ready = 1'b1; Clear_Overflow = 1'b0;
    m_wptr = 2'd0;
    repeat (2) tick();
    total++; if (Conf_Free_Out !== 1'b1) begin bad++; $display("FAIL rst_free act=%b req=1", Conf_Free_Out); end
    total++; if (Mem_Write !== 1'b0) begin bad++; $display("FAIL rst_mem_write act=%b req=0", Mem_Write); end
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL rst_level act=%0d req=0", Level); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow act=%b req=0", Overflow); end
    total++; if (Mem_Address !== 16'h0 || Mem_Data !== 16'h0) begin
      bad++; $display("FAIL rst_mem_bus act=%h/%h req=0000/0000", Mem_Address, Mem_Data); end
    Reset = 1'b1;
    repeat (3) tick();
    total++; if (Level !== 3'd0 || Mem_Write !== 1'b0 || Conf_Free_Out !== 1'b1) begin
      bad++; $display("FAIL idle_ready act=lvl%0d/w%b/f%b req=lvl0/w0/f1", Level, Mem_Write, Conf_Free_Out); end
  endtask

  task automatic test_release_high();
    Mem_Ready = 1'b0;
    Reset = 1'b0;
    Conf_Address_In = 16'h0AAA; Conf_Data_In = 16'h5555; Conf_Write_In = 1'b1;
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL release_high_level act=%0d req=0", Level); end
    Conf_Write_In = 1'b0;
    tick();
  endtask

  task automatic test_long_strobe();
    Mem_Ready = 1'b0;
    Conf_Address_In = 16'h0012; Conf_Data_In = 16'hBEEF; Conf_Write_In = 1'b1;
    tick();
    accept(16'h0012, 16'hBEEF);
    total++; if (Mem_Write !== 1'b1) begin bad++; $display("FAIL latency_mem_write act=%b req=1", Mem_Write); end
    repeat (4) tick();
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL long_level act=%0d req=1", Level); end
    total++; if (Mem_Address !== 16'h0012 || Mem_Data !== 16'hBEEF) begin
      bad++; $display("FAIL long_head act=%h/%h req=0012/beef", Mem_Address, Mem_Data); end
    total++; if (Conf_Free_Out !== 1'b1) begin bad++; $display("FAIL long_free act=%b req=1", Conf_Free_Out); end
    Conf_Write_In = 1'b0;
    tick();
    Mem_Ready = 1'b1;
    exp_w = sb.pop_front();
    total++; if (Mem_Address !== exp_w.addr || Mem_Data !== exp_w.data) begin
      bad++; $display("FAIL long_pop act=%h/%h req=%h/%h", Mem_Address, Mem_Data, exp_w.addr, exp_w.data); end
    tick();
    total++; if (Level !== 3'd0 || Mem_Write !== 1'b0 || Mem_Address !== 16'h0 || Mem_Data !== 16'h0) begin
      bad++; $display("FAIL long_empty act=lvl%0d/w%b/%h/%h req=lvl0/w0/0000/0000",
                      Level, Mem_Write, Mem_Address, Mem_Data); end
    Mem_Ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic exp_free;
    Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(16'h0101 + 16'(i), 16'hA000 + 16'(i), 1);
      accept(16'h0101 + 16'(i), 16'hA000 + 16'(i));
      exp_free = (i + 1 <= 2);
      total++; if (Level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level%0d act=%0d req=%0d", i, Level, i + 1); end
      total++; if (Conf_Free_Out !== exp_free) begin
        bad++; $display("FAIL fill_free%0d act=%b req=%b", i, Conf_Free_Out, exp_free); end
    end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf act=%b req=0", Overflow); end
    strobe(16'h0105, 16'hA004, 1);
    total++; if (Level !== 3'd4 || Overflow !== 1'b1) begin
      bad++; $display("FAIL drop act=lvl%0d/ovf%b req=lvl4/ovf1", Level, Overflow); end
    Clear_Overflow = 1'b1; tick(); Clear_Overflow = 1'b0;
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf act=%b req=0", Overflow); end
    Clear_Overflow = 1'b1;
    Conf_Address_In = 16'h0106; Conf_Write_In = 1'b1;
    tick();
    Clear_Overflow = 1'b0; Conf_Write_In = 1'b0;
    total++; if (Overflow !== 1'b1 || Level !== 3'd4) begin
      bad++; $display("FAIL set_wins act=ovf%b/lvl%0d req=ovf1/lvl4", Overflow, Level); end
    tick();
    Clear_Overflow = 1'b1; tick(); Clear_Overflow = 1'b0;
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf2 act=%b req=0", Overflow); end
  endtask

  task automatic test_full_push_pop();
    Mem_Ready = 1'b1;
    Conf_Address_In = 16'h0107; Conf_Data_In = 16'hA006; Conf_Write_In = 1'b1;
    exp_w = sb.pop_front();
    total++; if (Mem_Address !== exp_w.addr || Mem_Data !== exp_w.data) begin
      bad++; $display("FAIL fullpp_head act=%h/%h req=%h/%h", Mem_Address, Mem_Data, exp_w.addr, exp_w.data); end
    accept(16'h0107, 16'hA006);
    tick();
    Mem_Ready = 1'b0; Conf_Write_In = 1'b0;
    total++; if (Level !== 3'd4 || Overflow !== 1'b0 || Conf_Free_Out !== 1'b0) begin
      bad++; $display("FAIL fullpp act=lvl%0d/ovf%b/f%b req=lvl4/ovf0/f0", Level, Overflow, Conf_Free_Out); end
    tick();
  endtask

  task automatic test_drain();
    logic exp_free;
    Mem_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (Mem_Write !== 1'b1) begin bad++; $display("FAIL drain_valid%0d act=%b req=1", i, Mem_Write); end
      exp_w = sb.pop_front();
      total++; if (Mem_Address !== exp_w.addr || Mem_Data !== exp_w.data) begin
        bad++; $display("FAIL drain_head%0d act=%h/%h req=%h/%h", i, Mem_Address, Mem_Data, exp_w.addr, exp_w.data); end
      tick();
      exp_free = (3 - i <= 2);
      total++; if (Level !== 3'(3 - i) || Conf_Free_Out !== exp_free) begin
        bad++; $display("FAIL drain_level%0d act=lvl%0d/f%b req=lvl%0d/f%b", i, Level, Conf_Free_Out, 3 - i, exp_free); end
    end
    total++; if (Mem_Write !== 1'b0 || Mem_Address !== 16'h0 || Mem_Data !== 16'h0) begin
      bad++; $display("FAIL drain_empty act=w%b/%h/%h req=w0/0000/0000", Mem_Write, Mem_Address, Mem_Data); end
    tick();
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL pop_empty act=%0d req=0", Level); end
    Mem_Ready = 1'b0;
  endtask

  task automatic test_seu();
    Mem_Ready = 1'b0;
    strobe(16'h0201, 16'hC001, 1); accept(16'h0201, 16'hC001);
    strobe(16'h0202, 16'hC002, 2); accept(16'h0202, 16'hC002);
    force dut.u_wr_ptr.r_c0 = ~m_wptr;
    #1;
    total++; if (Level !== 3'd2 || Conf_Free_Out !== 1'b1 || Mem_Address !== 16'h0201) begin
      bad++; $display("FAIL seu_masked act=lvl%0d/f%b/%h req=lvl2/f1/0201", Level, Conf_Free_Out, Mem_Address); end
    total++; if (dut.u_wr_ptr.o_q !== m_wptr) begin
      bad++; $display("FAIL seu_voted act=%0d req=%0d", dut.u_wr_ptr.o_q, m_wptr); end
    release dut.u_wr_ptr.r_c0;
    Conf_Address_In = 16'h0203; Conf_Data_In = 16'hC003; Conf_Write_In = 1'b1;
    tick();
    accept(16'h0203, 16'hC003);
    Conf_Write_In = 1'b0;
    total++; if (dut.u_wr_ptr.r_c0 !== m_wptr) begin
      bad++; $display("FAIL seu_scrub act=%0d req=%0d", dut.u_wr_ptr.r_c0, m_wptr); end
    total++; if (Level !== 3'd3) begin bad++; $display("FAIL seu_level act=%0d req=3", Level); end
    tick();
    Mem_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_w = sb.pop_front();
      total++; if (Mem_Address !== exp_w.addr || Mem_Data !== exp_w.data) begin
        bad++; $display("FAIL seu_drain%0d act=%h/%h req=%h/%h", i, Mem_Address, Mem_Data, exp_w.addr, exp_w.data); end
      tick();
    end
    Mem_Ready = 1'b0;
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL seu_empty act=%0d req=0", Level); end
  endtask

  task automatic test_reset_mid();
    Mem_Ready = 1'b0;
    strobe(16'h0301, 16'hD001, 1); accept(16'h0301, 16'hD001);
    strobe(16'h0302, 16'hD002, 1); accept(16'h0302, 16'hD002);
    total++; if (Level !== 3'd2) begin bad++; $display("FAIL mid_level act=%0d req=2", Level); end
    #2;
    Reset = 1'b0;
    #1;
    total++; if (Level !== 3'd0 || Mem_Write !== 1'b0 || Conf_Free_Out !== 1'b1 || Overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset act=lvl%0d/w%b/f%b/ovf%b req=lvl0/w0/f1/ovf0",
                      Level, Mem_Write, Conf_Free_Out, Overflow); end
    total++; if (Mem_Address !== 16'h0 || Mem_Data !== 16'h0) begin
      bad++; $display("FAIL mid_reset_bus act=%h/%h req=0000/0000", Mem_Address, Mem_Data); end
    tick();
    Reset = 1'b1;
    sb.delete();
    m_wptr = 2'd0;
    repeat (2) tick();
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL mid_discard act=%0d req=0", Level); end
    strobe(16'h0C0C, 16'h1234, 1); accept(16'h0C0C, 16'h1234);
    exp_w = sb.pop_front();
    total++; if (Level !== 3'd1 || Mem_Address !== exp_w.addr || Mem_Data !== exp_w.data) begin
      bad++; $display("FAIL post_reset_push act=lvl%0d/%h/%h req=lvl1/%h/%h",
                      Level, Mem_Address, Mem_Data, exp_w.addr, exp_w.data); end
  endtask

  initial begin
    test_reset();
    test_release_high();
    test_long_strobe();
    test_fill_overflow();
    test_full_push_pop();
    test_drain();
    test_seu();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
